// File: rtl/decoder_arbiter_pkg.sv
// decoder_arbiter_pkg
//   Shared definitions for the decoder arbiter and anything else that has to
//   agree with it on frame geometry: FSM state encoding and the chunk/word
//   counts derived from the codeword length.
package decoder_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_RDY = 3'd2,
    READ     = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Input chunks needed to carry n_v LLRs, n_llrs per chunk.
  function automatic int n_in_chunks(input int n_v, input int n_llrs);
    return (n_v - 1) / n_llrs + 1;
  endfunction

  // Hard-decision words needed to carry n_v bits, width_out per word.
  function automatic int n_out_words(input int n_v, input int width_out);
    return (n_v - 1) / width_out + 1;
  endfunction

  // ceil(log2(n)) but never below 1, so a counter or index always has a bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decoder_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first set request at or after rr_ptr,
//   searching cyclically. The pointer itself lives in the parent.
// Ports:
//   req    : request vector
//   rr_ptr : highest-priority index for this pick
//   gnt    : one-hot winner (zero when no request)
//   idx    : index of the winner
//   any    : at least one request pending
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    int  j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
        found  = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/decoder_arbiter.sv
// decoder_arbiter
//   Shares one min-sum decoder core between N_REQ frame sources. A requester
//   is granted round-robin, its LLR chunks are streamed into the core, the
//   readout is triggered and the hard-decision words are returned tagged with
//   the requester id.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   req / grant         : per-requester request level / one-hot owner
//   src_data/src_valid  : per-requester chunk slices and valids
//   dec_*               : decoder core load and readout handshake
//   res_data/res_valid  : registered result word / one-hot word valid
//   res_last/res_id     : final word of frame / owning requester index
//   err_timeout         : one-cycle pulse when a frame is abandoned
module decoder_arbiter
  import decoder_arbiter_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int WIDTH_IN  = 8,
  parameter  int N_LLRS    = 4,
  parameter  int WIDTH_OUT = 8,
  parameter  int N_V       = 31,
  parameter  int TIMEOUT   = 1023,
  localparam int ID_W      = clog2_min1(N_REQ),
  localparam int CH_W      = N_LLRS * WIDTH_IN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  output logic [N_REQ-1:0]       grant,
  input  logic [N_REQ*CH_W-1:0]  src_data,
  input  logic [N_REQ-1:0]       src_valid,
  output logic [CH_W-1:0]        dec_databus_in,
  output logic                   dec_first_data,
  output logic                   dec_data_valid,
  input  logic                   dec_busy,
  input  logic                   dec_out_ready,
  output logic                   dec_first_data_out,
  input  logic [WIDTH_OUT-1:0]   dec_databus_out,
  input  logic                   dec_data_valid_out,
  output logic [WIDTH_OUT-1:0]   res_data,
  output logic [N_REQ-1:0]       res_valid,
  output logic                   res_last,
  output logic [ID_W-1:0]        res_id,
  output logic                   err_timeout
);

  localparam int N_IN_CHUNKS = n_in_chunks(N_V, N_LLRS);
  localparam int N_OUT_WORDS = n_out_words(N_V, WIDTH_OUT);
  localparam int IN_W        = clog2_min1(N_IN_CHUNKS);
  localparam int OUT_W       = clog2_min1(N_OUT_WORDS);
  localparam int TMR_W       = clog2_min1(TIMEOUT + 1);

  localparam logic [IN_W-1:0]  LAST_IN  = IN_W'(N_IN_CHUNKS - 1);
  localparam logic [OUT_W-1:0] LAST_OUT = OUT_W'(N_OUT_WORDS - 1);
  // The timer starts at 0 on WAIT_RDY entry, so TIMEOUT cycles end at TIMEOUT-1.
  localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [IN_W-1:0]  in_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic [TMR_W-1:0] timer;

  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // Owner's chunk goes straight to the core while loading; zero otherwise.
  always_comb begin
    dec_databus_in = '0;
    dec_data_valid = 1'b0;
    if (state == LOAD) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ID_W'(i) == res_id) begin
          dec_databus_in = src_data[i*CH_W +: CH_W];
          dec_data_valid = src_valid[i];
        end
      end
    end
    dec_first_data = dec_data_valid && (in_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      grant              <= '0;
      res_id             <= '0;
      rr_ptr             <= '0;
      in_cnt             <= '0;
      out_cnt            <= '0;
      timer              <= '0;
      res_data           <= '0;
      res_valid          <= '0;
      res_last           <= 1'b0;
      err_timeout        <= 1'b0;
      dec_first_data_out <= 1'b0;
    end else begin
      res_valid          <= '0;
      res_last           <= 1'b0;
      err_timeout        <= 1'b0;
      dec_first_data_out <= 1'b0;
      case (state)
        IDLE: begin
          // A busy core is still flushing the previous frame.
          if (arb_any && !dec_busy) begin
            grant  <= arb_gnt;
            res_id <= arb_idx;
            in_cnt <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (dec_data_valid) begin
            if (in_cnt == LAST_IN) begin
              in_cnt <= '0;
              timer  <= '0;
              state  <= WAIT_RDY;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        WAIT_RDY: begin
          if (dec_out_ready) begin
            dec_first_data_out <= 1'b1;
            timer              <= '0;
            out_cnt            <= '0;
            state              <= READ;
          end else if (timer == LAST_TMR) begin
            err_timeout <= 1'b1;
            timer       <= '0;
            state       <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        READ: begin
          if (dec_data_valid_out) begin
            res_data  <= dec_databus_out;
            res_valid <= grant;
            if (out_cnt == LAST_OUT) begin
              res_last <= 1'b1;
              out_cnt  <= '0;
              state    <= DONE;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          grant  <= '0;
          rr_ptr <= (res_id == LAST_ID) ? '0 : res_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_arbiter.sv
// tb_decoder_arbiter
//   Directed bench for decoder_arbiter at default parameters. A small inline
//   decoder model drives dec_busy / dec_out_ready / the result words.
module tb_decoder_arbiter;

  localparam int NR      = 4;
  localparam int CW      = 32;
  localparam int N_IN    = 8;
  localparam int N_OUT   = 4;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     grant;
  logic [NR*CW-1:0]  src_data = '0;
  logic [NR-1:0]     src_valid = '0;
  logic [CW-1:0]     dec_databus_in;
  logic              dec_first_data;
  logic              dec_data_valid;
  logic              dec_busy = 1'b0;
  logic              dec_out_ready = 1'b0;
  logic              dec_first_data_out;
  logic [7:0]        dec_databus_out = '0;
  logic              dec_data_valid_out = 1'b0;
  logic [7:0]        res_data;
  logic [NR-1:0]     res_valid;
  logic              res_last;
  logic [1:0]        res_id;
  logic              err_timeout;

  int n_cmp = 0;
  int n_mis = 0;

  decoder_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .req                (req),
    .grant              (grant),
    .src_data           (src_data),
    .src_valid          (src_valid),
    .dec_databus_in     (dec_databus_in),
    .dec_first_data     (dec_first_data),
    .dec_data_valid     (dec_data_valid),
    .dec_busy           (dec_busy),
    .dec_out_ready      (dec_out_ready),
    .dec_first_data_out (dec_first_data_out),
    .dec_databus_out    (dec_databus_out),
    .dec_data_valid_out (dec_data_valid_out),
    .res_data           (res_data),
    .res_valid          (res_valid),
    .res_last           (res_last),
    .res_id             (res_id),
    .err_timeout        (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] chunk(input int r, input int k);
    return {8'(8'hA0 + r), 8'(k), 8'(r * 16 + k), 8'h5A};
  endfunction

  function automatic logic [7:0] word(input int r, input int j);
    return 8'(r * 40 + j * 7 + 1);
  endfunction

  task automatic wait_grant(input int r);
    logic [NR-1:0] oh;
    int cyc;
    oh  = 4'b0001 << r;
    cyc = 0;
    while (grant == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("grant", 64'(grant), 64'(oh));
    chk("res_id_at_grant", 64'(res_id), 64'(r));
  endtask

  // Stream n chunks; stall pattern gives valid on cycles 0,3,6,... (1,0,0,1,..)
  task automatic load_chunks(input int r, input int n, input bit stall);
    int  k;
    int  cyc;
    bit  v;
    logic [NR-1:0] oh;
    oh  = 4'b0001 << r;
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 64) begin
      v = stall ? (cyc % 3 == 0) : 1'b1;
      // Non-granted requesters show valid while the owner stalls.
      src_valid = v ? 4'hF : ~oh;
      for (int i = 0; i < NR; i++) src_data[i*CW +: CW] = chunk(i, k);
      #1;
      chk("dec_data_valid", 64'(dec_data_valid), 64'(v));
      if (v) begin
        chk("dec_first_data", 64'(dec_first_data), 64'(k == 0));
        chk("dec_chunk", 64'(dec_databus_in), 64'(chunk(r, k)));
        k++;
      end else begin
        chk("first_on_stall", 64'(dec_first_data), 64'd0);
      end
      @(negedge clk);
      cyc++;
    end
    chk("chunks_sent", 64'(k), 64'(n));
  endtask

  task automatic do_frame(input int r, input bit stall, input bit to, input bit drop);
    int  cnt;
    bit  seen;
    logic [NR-1:0] oh;
    oh = 4'b0001 << r;
    dec_busy = 1'b0;
    wait_grant(r);
    dec_busy = 1'b1;
    if (drop) req = '0;
    load_chunks(r, N_IN, stall);
    src_valid = 4'hF;
    #1;
    chk("no_extra_chunk", 64'(dec_data_valid), 64'd0);
    src_valid = '0;
    if (to) begin
      cnt  = 0;
      seen = 1'b0;
      while (!err_timeout && cnt < TIMEOUT + 50) begin
        @(negedge clk);
        cnt++;
        if (res_valid != '0 || dec_first_data_out) seen = 1'b1;
      end
      chk("timeout_cycles", 64'(cnt), 64'(TIMEOUT));
      chk("timeout_no_words", 64'(seen), 64'd0);
    end else begin
      repeat (3) @(negedge clk);
      chk("no_early_readout", 64'(dec_first_data_out), 64'd0);
      dec_out_ready = 1'b1;
      @(negedge clk);
      dec_out_ready = 1'b0;
      chk("readout_pulse", 64'(dec_first_data_out), 64'd1);
      for (int j = 0; j < N_OUT; j++) begin
        dec_data_valid_out = 1'b1;
        dec_databus_out    = word(r, j);
        @(negedge clk);
        chk("readout_once", 64'(dec_first_data_out), 64'd0);
        chk("res_valid", 64'(res_valid), 64'(oh));
        chk("res_data", 64'(res_data), 64'(word(r, j)));
        chk("res_last", 64'(res_last), 64'(j == N_OUT - 1));
        chk("res_id", 64'(res_id), 64'(r));
      end
      dec_data_valid_out = 1'b0;
      dec_databus_out    = '0;
    end
    @(negedge clk);
    chk("grant_cleared", 64'(grant), 64'd0);
    chk("res_valid_idle", 64'(res_valid), 64'd0);
    chk("err_one_cycle", 64'(err_timeout), 64'd0);
    @(negedge clk);
    chk("busy_blocks_grant", 64'(grant), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_last", 64'(res_last), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_rd_pulse", 64'(dec_first_data_out), 64'd0);
    chk("rst_dv", 64'(dec_data_valid), 64'd0);
    chk("rst_bus", 64'(dec_databus_in), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single requester
    req = 4'b0001;
    do_frame(0, 1'b0, 1'b0, 1'b0);
    req = '0;

    // Reset while idle restores pointer to 0
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_rst_grant", 64'(grant), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Round robin with all requesters: 0 (stalled source), 1, 2 (timeout), 3, 0
    req = 4'b1111;
    do_frame(0, 1'b1, 1'b0, 1'b0);
    do_frame(1, 1'b0, 1'b0, 1'b0);
    do_frame(2, 1'b0, 1'b1, 1'b0);
    do_frame(3, 1'b0, 1'b0, 1'b0);
    do_frame(0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of loading requester 1's frame
    dec_busy = 1'b0;
    wait_grant(1);
    dec_busy = 1'b1;
    load_chunks(1, 4, 1'b0);
    src_valid = 4'hF;
    rst = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(grant), 64'd0);
    chk("mid_rst_res_id", 64'(res_id), 64'd0);
    chk("mid_rst_dv", 64'(dec_data_valid), 64'd0);
    chk("mid_rst_bus", 64'(dec_databus_in), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    src_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0001;
    do_frame(0, 1'b0, 1'b0, 1'b0);

    // Requester 2 withdraws after grant; frame still completes
    req = 4'b0100;
    do_frame(2, 1'b0, 1'b0, 1'b1);

    // Pointer now at 3
    req = 4'b1111;
    do_frame(3, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
